// File: rtl/id_ex_stage.sv
// Decode->Execute pipeline register with load-use hazard detection, branch flush,
// and a saturating counter of inserted load-use bubbles.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             FlushE,
    input  logic             ValidD,
    input  logic             RegWriteD,
    input  logic             ALUSrcD,
    input  logic             MemWriteD,
    input  logic             ResultSrcD,
    input  logic             BranchD,
    input  logic [2:0]       ALUControlD,
    input  logic [XLEN-1:0]  RD1D,
    input  logic [XLEN-1:0]  RD2D,
    input  logic [XLEN-1:0]  ImmExtD,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  logic [XLEN-1:0]  PCD,
    input  logic [XLEN-1:0]  PCPlus4D,
    output logic             ValidE,
    output logic             RegWriteE,
    output logic             ALUSrcE,
    output logic             MemWriteE,
    output logic             ResultSrcE,
    output logic             BranchE,
    output logic [2:0]       ALUControlE,
    output logic [XLEN-1:0]  RD1E,
    output logic [XLEN-1:0]  RD2E,
    output logic [XLEN-1:0]  ImmExtE,
    output logic [4:0]       Rs1E,
    output logic [4:0]       Rs2E,
    output logic [4:0]       RdE,
    output logic [XLEN-1:0]  PCE,
    output logic [XLEN-1:0]  PCPlus4E,
    output logic             StallF,
    output logic             StallD,
    output logic [CNT_W-1:0] BubbleCount
);

    logic load_use;
    logic bubble;

    // Rs2D is compared even for I-type instructions; the rare false stall is harmless.
    always_comb begin
        load_use = ValidE & ResultSrcE & RegWriteE & ValidD & (RdE != 5'd0)
                 & ((RdE == Rs1D) | (RdE == Rs2D));
        bubble   = FlushE | load_use;
        StallF   = load_use & ~FlushE & ~rst;
        StallD   = StallF;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            ValidE      <= 1'b0;
            RegWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            MemWriteE   <= 1'b0;
            ResultSrcE  <= 1'b0;
            BranchE     <= 1'b0;
            ALUControlE <= 3'd0;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            Rs1E        <= 5'd0;
            Rs2E        <= 5'd0;
            RdE         <= 5'd0;
            PCE         <= '0;
            PCPlus4E    <= '0;
        end else begin
            // An empty D slot must never write the register file or memory.
            ValidE      <= ValidD;
            RegWriteE   <= RegWriteD  & ValidD;
            ALUSrcE     <= ALUSrcD    & ValidD;
            MemWriteE   <= MemWriteD  & ValidD;
            ResultSrcE  <= ResultSrcD & ValidD;
            BranchE     <= BranchD    & ValidD;
            ALUControlE <= ValidD ? ALUControlD : 3'd0;
            RD1E        <= RD1D;
            RD2E        <= RD2D;
            ImmExtE     <= ImmExtD;
            Rs1E        <= Rs1D;
            Rs2E        <= Rs2D;
            RdE         <= RdD;
            PCE         <= PCD;
            PCPlus4E    <= PCPlus4D;
        end
    end

    // Flush takes priority over load-use, so a squashed slot is not counted as a bubble.
    always_ff @(posedge clk) begin
        if (rst)
            BubbleCount <= '0;
        else if (load_use && !FlushE && (BubbleCount != {CNT_W{1'b1}}))
            BubbleCount <= BubbleCount + 1'b1;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; a second 3-bit-counter instance exercises saturation.
module tb_id_ex_stage;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, FlushE, ValidD, RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, BranchD;
    logic [2:0]      ALUControlD;
    logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
    logic [4:0]      Rs1D, Rs2D, RdD;

    logic            ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, StallF, StallD;
    logic [2:0]      ALUControlE;
    logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]      Rs1E, Rs2E, RdE;
    logic [15:0]     BubbleCount;

    logic            s_ValidE, s_RegWriteE, s_ALUSrcE, s_MemWriteE, s_ResultSrcE, s_BranchE;
    logic            s_StallF, s_StallD;
    logic [2:0]      s_ALUControlE;
    logic [XLEN-1:0] s_RD1E, s_RD2E, s_ImmExtE, s_PCE, s_PCPlus4E;
    logic [4:0]      s_Rs1E, s_Rs2E, s_RdE;
    logic [2:0]      s_BubbleCount;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .FlushE(FlushE), .ValidD(ValidD), .RegWriteD(RegWriteD),
        .ALUSrcD(ALUSrcD), .MemWriteD(MemWriteD), .ResultSrcD(ResultSrcD), .BranchD(BranchD),
        .ALUControlD(ALUControlD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ValidE(ValidE), .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .StallF(StallF), .StallD(StallD),
        .BubbleCount(BubbleCount)
    );

    id_ex_stage #(.XLEN(XLEN), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .FlushE(FlushE), .ValidD(ValidD), .RegWriteD(RegWriteD),
        .ALUSrcD(ALUSrcD), .MemWriteD(MemWriteD), .ResultSrcD(ResultSrcD), .BranchD(BranchD),
        .ALUControlD(ALUControlD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ValidE(s_ValidE), .RegWriteE(s_RegWriteE), .ALUSrcE(s_ALUSrcE),
        .MemWriteE(s_MemWriteE), .ResultSrcE(s_ResultSrcE), .BranchE(s_BranchE),
        .ALUControlE(s_ALUControlE), .RD1E(s_RD1E), .RD2E(s_RD2E), .ImmExtE(s_ImmExtE),
        .Rs1E(s_Rs1E), .Rs2E(s_Rs2E), .RdE(s_RdE), .PCE(s_PCE), .PCPlus4E(s_PCPlus4E),
        .StallF(s_StallF), .StallD(s_StallD), .BubbleCount(s_BubbleCount)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit later, away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic rs, input logic mw,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] rd1);
        ValidD = v; RegWriteD = rw; ResultSrcD = rs; MemWriteD = mw;
        Rs1D = rs1; Rs2D = rs2; RdD = rd; RD1D = rd1;
        ALUSrcD = 1'b0; BranchD = 1'b0; ALUControlD = 3'b000;
        RD2D = 32'h0; ImmExtD = 32'h0; PCD = 32'h0; PCPlus4D = 32'h0;
    endtask

    initial begin
        // Reset for 2 cycles with random inputs
        rst = 1'b1; FlushE = 1'b0;
        ValidD = 1'b1; RegWriteD = $urandom; ALUSrcD = $urandom; MemWriteD = $urandom;
        ResultSrcD = $urandom; BranchD = $urandom; ALUControlD = 3'($urandom);
        RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom; PCD = $urandom; PCPlus4D = $urandom;
        Rs1D = 5'($urandom); Rs2D = 5'($urandom); RdD = 5'($urandom);
        step(); step();
        check("rst_valid", ValidE, 0);
        check("rst_regwrite", RegWriteE, 0);
        check("rst_rd1", RD1E, 0);
        check("rst_pc", PCE, 0);
        check("rst_rd", RdE, 0);
        check("rst_stallf", StallF, 0);
        check("rst_count", BubbleCount, 0);

        // Plain pass-through
        rst = 1'b0;
        drive(1, 1, 0, 0, 5'd1, 5'd2, 5'd5, 32'h11);
        ALUControlD = 3'b010; PCD = 32'h100; PCPlus4D = 32'h104; ImmExtD = 32'hFFFF_FFF0;
        #1;
        check("pass_stall_pre", StallF, 0);
        step();
        check("pass_valid", ValidE, 1);
        check("pass_regwrite", RegWriteE, 1);
        check("pass_aluctl", ALUControlE, 3'b010);
        check("pass_rd1", RD1E, 32'h11);
        check("pass_rd", RdE, 5);
        check("pass_pc", PCE, 32'h100);
        check("pass_pc4", PCPlus4E, 32'h104);
        check("pass_imm", ImmExtE, 32'hFFFF_FFF0);
        check("pass_stall", StallF, 0);

        // Load-use on Rs1: lw x5 then add x6,x5,x7
        drive(1, 1, 1, 0, 5'd2, 5'd0, 5'd5, 32'h0);
        step();
        check("lw_in_e", ResultSrcE, 1);
        drive(1, 1, 0, 0, 5'd5, 5'd7, 5'd6, 32'hAA);
        #1;
        check("lu_stallf", StallF, 1);
        check("lu_stalld", StallD, 1);
        step();
        check("lu_bubble_valid", ValidE, 0);
        check("lu_bubble_regwrite", RegWriteE, 0);
        check("lu_count", BubbleCount, 1);
        check("lu_stall_drop", StallF, 0);
        step();
        check("lu_add_valid", ValidE, 1);
        check("lu_add_rd", RdE, 6);
        check("lu_add_rd1", RD1E, 32'hAA);
        check("lu_count_hold", BubbleCount, 1);

        // Load to x0 never stalls
        drive(1, 1, 1, 0, 5'd3, 5'd0, 5'd0, 32'h0);
        step();
        drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd7, 32'h33);
        #1;
        check("x0_nostall", StallF, 0);
        step();
        check("x0_add_valid", ValidE, 1);
        check("x0_add_rd", RdE, 7);
        check("x0_count", BubbleCount, 1);

        // Load-use through Rs2 with a simultaneous flush
        drive(1, 1, 1, 0, 5'd1, 5'd0, 5'd5, 32'h0);
        step();
        drive(1, 0, 0, 1, 5'd9, 5'd5, 5'd0, 32'h44);
        #1;
        check("rs2_stall", StallF, 1);
        FlushE = 1'b1;
        #1;
        check("flush_stallf", StallF, 0);
        check("flush_stalld", StallD, 0);
        step();
        FlushE = 1'b0;
        check("flush_valid", ValidE, 0);
        check("flush_memwrite", MemWriteE, 0);
        check("flush_count", BubbleCount, 1);

        // Saturation on the 3-bit counter; 16-bit counter keeps counting
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 1, 0, 5'd5, 5'd0, 5'd5, 32'h0);
            step();
            check("sat_stall", StallF, 1);
            step();
            check("sat_count16", BubbleCount, 32'(2 + i));
            check("sat_count3", s_BubbleCount, (2 + i) > 7 ? 7 : 32'(2 + i));
        end

        // Reset in mid-stall
        drive(1, 1, 1, 0, 5'd5, 5'd0, 5'd5, 32'h0);
        step();
        check("midrst_stall", StallF, 1);
        rst = 1'b1;
        #1;
        check("midrst_stall_drop", StallF, 0);
        check("midrst_stalld_drop", StallD, 0);
        step();
        check("midrst_valid", ValidE, 0);
        check("midrst_count", BubbleCount, 0);
        check("midrst_count3", s_BubbleCount, 0);
        rst = 1'b0;

        // Empty D slot forces control bits off
        drive(0, 1, 1, 1, 5'd1, 5'd2, 5'd3, 32'h55);
        BranchD = 1'b1;
        step();
        check("inv_valid", ValidE, 0);
        check("inv_regwrite", RegWriteE, 0);
        check("inv_memwrite", MemWriteE, 0);
        check("inv_branch", BranchE, 0);
        check("inv_resultsrc", ResultSrcE, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
